// File: rtl/mem_access_if.sv
// Bundle of every handshake and RAM signal between the arbiter and its two
// requesters. The arbiter takes the slave view; the surrounding system (or bench) takes the master view.
interface mem_access_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_ack;
    logic          core_finish;
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ld_rdata;
    logic          ld_ack;
    logic          ld_done;
    logic          proc_enable;
    logic [1:0]    phase;
    logic          addr_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_finish,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_done, mem_rdata,
        output core_rdata, core_ack, ld_rdata, ld_ack,
        output proc_enable, phase, addr_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_finish,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_done, mem_rdata,
        input  core_rdata, core_ack, ld_rdata, ld_ack,
        input  proc_enable, phase, addr_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Single-port data RAM arbiter between the convolution core and the image loader.
// Sequences LOAD -> RUN -> DRAIN and runs one unpipelined 3-cycle access at a time.
module mem_access_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MEM_DEPTH = 256
) (
    input logic         clk,
    input logic         rst_n,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    typedef enum logic [1:0] {PH_LOAD = 2'b00, PH_RUN = 2'b01, PH_DRAIN = 2'b10} phase_t;

    localparam logic          GNT_CORE = 1'b0;
    localparam logic          GNT_LD   = 1'b1;
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(MEM_DEPTH);

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic          rr_q, rr_d;
    logic          gnt_q, gnt_d;
    logic          we_q, we_d;
    logic          inr_q, inr_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          proc_enable_q, proc_enable_d;
    logic          addr_err_q, addr_err_d;
    logic [DW-1:0] core_hold_q, core_hold_d;
    logic [DW-1:0] ld_hold_q, ld_hold_d;

    logic          core_elig, ld_elig, sel_ld, sel_we, sel_in;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata, rd_val;
    logic          core_ack, ld_ack;

    always_comb begin
        core_elig = bus.core_req && (phase_q == PH_RUN);
        ld_elig   = bus.ld_req;
        // rr_q holds the last winner, so a waiting side never loses two grants in a row
        sel_ld    = ld_elig && (!core_elig || rr_q == GNT_CORE);
        sel_we    = sel_ld ? bus.ld_we    : bus.core_we;
        sel_addr  = sel_ld ? bus.ld_addr  : bus.core_addr;
        sel_wdata = sel_ld ? bus.ld_wdata : bus.core_wdata;
        sel_in    = {1'b0, sel_addr} < DEPTH;
        rd_val    = inr_q ? bus.mem_rdata : '0;
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_LOAD:  if (bus.ld_done)     phase_d = PH_RUN;
            PH_RUN:   if (bus.core_finish) phase_d = PH_DRAIN;
            default:  phase_d = PH_DRAIN;
        endcase
        proc_enable_d = (phase_d == PH_RUN);
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        inr_d       = inr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        addr_err_d  = addr_err_q;
        core_hold_d = core_hold_q;
        ld_hold_d   = ld_hold_q;
        case (state_q)
            IDLE: if (core_elig || ld_elig) begin
                state_d     = ACCESS;
                gnt_d       = sel_ld;
                rr_d        = sel_ld;
                we_d        = sel_we;
                inr_d       = sel_in;
                mem_en_d    = sel_in;
                mem_we_d    = sel_in && sel_we;
                mem_addr_d  = sel_in ? sel_addr  : '0;
                mem_wdata_d = sel_in ? sel_wdata : '0;
            end
            ACCESS: begin
                state_d = ACK;
                if (!inr_q) addr_err_d = 1'b1;
            end
            ACK: begin
                state_d = IDLE;
                if (!we_q && gnt_q == GNT_CORE) core_hold_d = rd_val;
                if (!we_q && gnt_q == GNT_LD)   ld_hold_d   = rd_val;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            phase_q       <= PH_LOAD;
            rr_q          <= GNT_CORE;
            gnt_q         <= GNT_CORE;
            we_q          <= 1'b0;
            inr_q         <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            proc_enable_q <= 1'b0;
            addr_err_q    <= 1'b0;
            core_hold_q   <= '0;
            ld_hold_q     <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            rr_q          <= rr_d;
            gnt_q         <= gnt_d;
            we_q          <= we_d;
            inr_q         <= inr_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            proc_enable_q <= proc_enable_d;
            addr_err_q    <= addr_err_d;
            core_hold_q   <= core_hold_d;
            ld_hold_q     <= ld_hold_d;
        end
    end

    // Read data is passed straight through in the ack cycle, then held
    assign core_ack        = (state_q == ACK) && (gnt_q == GNT_CORE);
    assign ld_ack          = (state_q == ACK) && (gnt_q == GNT_LD);
    assign bus.core_ack    = core_ack;
    assign bus.ld_ack      = ld_ack;
    assign bus.core_rdata  = (core_ack && !we_q) ? rd_val : core_hold_q;
    assign bus.ld_rdata    = (ld_ack && !we_q) ? rd_val : ld_hold_q;
    assign bus.proc_enable = proc_enable_q;
    assign bus.phase       = phase_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboarded bench for mem_access_arbiter: directed phase scenarios plus
// randomized concurrent core/loader traffic on disjoint address regions.
module tb_mem_access_arbiter;
    localparam int DEPTH = 200;

    typedef struct {
        logic       we;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_if #(.AW(8), .DW(8)) bus ();

    mem_access_arbiter #(.AW(8), .DW(8), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];
    exp_t exp_core[$];
    exp_t exp_ld[$];
    int total = 0;
    int bad = 0;
    int core_ack_cnt = 0;
    int ld_ack_cnt = 0;
    logic last_side = 1'b0;   // 0 = core, 1 = loader; reset pointer is core
    logic [7:0] core_last = 8'h00;
    logic [7:0] ld_last = 8'h00;

    always @(posedge clk)
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= ram[bus.mem_addr];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic core_issue(input logic we, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        bus.core_we = we; bus.core_addr = a; bus.core_wdata = d; bus.core_req = 1'b1;
        e.we = we;
        e.data = (int'(a) < DEPTH) ? ref_mem[a] : 8'h00;
        if (we && int'(a) < DEPTH) ref_mem[a] = d;
        exp_core.push_back(e);
    endtask

    task automatic ld_issue(input logic we, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d; bus.ld_req = 1'b1;
        e.we = we;
        e.data = (int'(a) < DEPTH) ? ref_mem[a] : 8'h00;
        if (we && int'(a) < DEPTH) ref_mem[a] = d;
        exp_ld.push_back(e);
    endtask

    task automatic wait_core_ack(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.core_ack && n < 50);
        if (!bus.core_ack) n = -1;
    endtask

    task automatic wait_ld_ack(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ld_ack && n < 50);
        if (!bus.ld_ack) n = -1;
    endtask

    // Monitor: pops the scoreboard on every ack; writes must leave the held rdata alone
    initial begin
        exp_t e;
        logic prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 1'b0; core_last = 8'h00; ld_last = 8'h00; last_side = 1'b0;
            end else begin
                if (bus.mem_en) chk("mem_en_back_to_back", prev_en, 0);
                prev_en = bus.mem_en;
                if (bus.core_ack) begin
                    core_ack_cnt++; last_side = 1'b0;
                    if (exp_core.size() == 0) chk("core_unexpected_ack", 1, 0);
                    else begin
                        e = exp_core.pop_front();
                        if (!e.we) begin chk("core_rdata", bus.core_rdata, e.data); core_last = e.data; end
                        else chk("core_rdata_hold", bus.core_rdata, core_last);
                    end
                end
                if (bus.ld_ack) begin
                    ld_ack_cnt++; last_side = 1'b1;
                    if (exp_ld.size() == 0) chk("ld_unexpected_ack", 1, 0);
                    else begin
                        e = exp_ld.pop_front();
                        if (!e.we) begin chk("ld_rdata", bus.ld_rdata, e.data); ld_last = e.data; end
                        else chk("ld_rdata_hold", bus.ld_rdata, ld_last);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, cnt0, k, cc, lc;
        logic [7:0] v;
        logic saw_en, exp_side, side;
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0; bus.core_finish = 0;
        bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = 0; bus.ld_wdata = 0; bus.ld_done = 0;
        bus.mem_rdata = 0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom); ram[i] = v; ref_mem[i] = v;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_phase", bus.phase, 0);
        chk("rst_proc_enable", bus.proc_enable, 0);
        chk("rst_addr_err", bus.addr_err, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_core_rdata", bus.core_rdata, 0);
        chk("rst_ld_rdata", bus.ld_rdata, 0);
        rst_n = 1'b1;

        // Reset mid-ACCESS aborts a loader write with no ack
        bus.ld_we = 1; bus.ld_addr = 8'd0; bus.ld_wdata = 8'hAA; bus.ld_req = 1;
        @(negedge clk);
        chk("abort_mem_en_access", bus.mem_en, 1);
        chk("abort_mem_we_access", bus.mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_en_async", bus.mem_en, 0);
        chk("abort_mem_we_async", bus.mem_we, 0);
        chk("abort_phase", bus.phase, 0);
        bus.ld_req = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_ld_ack", ld_ack_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LOAD: 9-word burst with req held, acks 3 cycles apart
        ld_issue(1, 8'd0, 8'h11);
        for (int i = 0; i < 9; i++) begin
            wait_ld_ack(n);
            chk("ld_burst_latency", n, (i == 0) ? 2 : 3);
            if (i < 8) ld_issue(1, 8'(i + 1), 8'(8'h12 + i));
            else bus.ld_req = 0;
        end
        for (int i = 0; i < 6; i++) begin
            ld_issue(1'($urandom_range(0, 1)), 8'($urandom_range(9, 99)), 8'($urandom));
            wait_ld_ack(n);
            chk("ld_load_ack", (n >= 2 && n <= 3), 1);
            bus.ld_req = 0;
            @(negedge clk);
        end
        chk("load_proc_enable", bus.proc_enable, 0);

        // LOAD lockout for the core, then ld_done starts RUN
        core_issue(0, 8'd0, 8'h00);
        cnt0 = core_ack_cnt;
        repeat (8) @(negedge clk);
        chk("lockout_no_core_ack", core_ack_cnt, cnt0);
        bus.ld_done = 1;
        @(negedge clk);
        bus.ld_done = 0;
        chk("run_proc_enable", bus.proc_enable, 1);
        chk("run_phase", bus.phase, 1);
        wait_core_ack(n);
        chk("lockout_core_latency", (n < 0) ? -1 : n + 1, 3);
        bus.core_req = 0;
        @(negedge clk);

        // Contention: both sides hold reads; grants alternate starting opposite the last winner
        exp_side = ~last_side;
        core_issue(0, 8'd4, 8'h00);
        ld_issue(0, 8'd5, 8'h00);
        cc = 0; lc = 0; k = 0; n = 0;
        while ((cc < 2 || lc < 2) && n < 40) begin
            @(negedge clk); n++;
            if (bus.core_ack || bus.ld_ack) begin
                side = bus.ld_ack;
                chk("rr_order", side, exp_side);
                exp_side = ~exp_side; k++;
                if (!side) begin cc++; if (cc < 2) core_issue(0, 8'd4, 8'h00); else bus.core_req = 0; end
                else begin lc++; if (lc < 2) ld_issue(0, 8'd5, 8'h00); else bus.ld_req = 0; end
            end
        end
        chk("rr_all_acks", k, 4);
        bus.core_req = 0; bus.ld_req = 0;
        chk("rr_core_rdata", bus.core_rdata, 8'h15);
        chk("rr_ld_rdata", bus.ld_rdata, 8'h16);
        @(negedge clk);

        // ld_done in RUN is ignored
        bus.ld_done = 1; @(negedge clk); bus.ld_done = 0; @(negedge clk);
        chk("run_ld_done_ignored", bus.phase, 1);

        // Out-of-range core read
        chk("oor_err_before", bus.addr_err, 0);
        core_issue(0, 8'd250, 8'h00);
        saw_en = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (bus.mem_en) saw_en = 1;
        end while (!bus.core_ack && n < 50);
        chk("oor_ack_seen", bus.core_ack, 1);
        chk("oor_mem_en", saw_en, 0);
        chk("oor_addr_err", bus.addr_err, 1);
        bus.core_req = 0;
        @(negedge clk);

        // Random concurrent traffic on disjoint regions
        fork
            begin
                int lat, gap;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin bus.core_req = 0; repeat (gap) @(negedge clk); end
                    core_issue(1'($urandom_range(0, 1)), 8'($urandom_range(100, 255)), 8'($urandom));
                    wait_core_ack(lat);
                    chk("core_rand_latency", (lat >= 2 && lat <= 6), 1);
                end
                bus.core_req = 0;
            end
            begin
                int lat, gap;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin bus.ld_req = 0; repeat (gap) @(negedge clk); end
                    ld_issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 99)), 8'($urandom));
                    wait_ld_ack(lat);
                    chk("ld_rand_latency", (lat >= 2 && lat <= 6), 1);
                end
                bus.ld_req = 0;
            end
        join
        @(negedge clk);
        chk("addr_err_sticky", bus.addr_err, 1);

        // core_finish while a core write is in ACCESS
        v = 8'($urandom);
        core_issue(1, 8'd42, v);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.mem_en && n < 50);
        chk("finish_access_seen", bus.mem_en, 1);
        bus.core_finish = 1;
        wait_core_ack(n);
        chk("finish_write_acked", (n > 0), 1);
        chk("drain_phase", bus.phase, 2);
        chk("drain_proc_enable", bus.proc_enable, 0);
        bus.core_req = 0;
        @(negedge clk);
        ld_issue(0, 8'd42, 8'h00);
        wait_ld_ack(n);
        chk("drain_ld_ack", (n > 0), 1);
        chk("drain_ld_readback", bus.ld_rdata, v);
        bus.ld_req = 0;

        // DRAIN is terminal and locks the core out
        bus.ld_done = 1; @(negedge clk); bus.ld_done = 0;
        cnt0 = core_ack_cnt;
        bus.core_we = 0; bus.core_addr = 8'd1; bus.core_req = 1;
        repeat (8) @(negedge clk);
        bus.core_req = 0;
        chk("drain_core_locked", core_ack_cnt, cnt0);
        chk("drain_terminal", bus.phase, 2);
        chk("scoreboard_empty", exp_core.size() + exp_ld.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
